// File: rtl/pipelined_carry_adder.sv
// Carry-chunked pipelined adder/subtractor with valid/ready handshake on both sides.
// Subtraction is built only when PIPELINED_CARRY_ADDER_SUB_EN is defined.
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;

`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  assign y_eff   = sub ? ~y : y;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign y_eff      = y;
  assign cin_eff    = cin;
`endif

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_param
    $error("pipelined_carry_adder: WIDTH must be a positive multiple of CHUNK");
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage
    localparam int SW = WIDTH - gi * CHUNK;  // operand bits not yet added on entry
    localparam int LO = gi * CHUNK;

    logic [SW-1:0]       src_x;
    logic [SW-1:0]       src_y;
    logic                src_c;
    logic                src_v;
    logic [LO+CHUNK-1:0] sum_next;
    logic [CHUNK:0]      add;

    logic                valid_reg;
    logic                carry_reg;
    logic [LO+CHUNK-1:0] sum_reg;

    assign add = {1'b0, src_x[CHUNK-1:0]} + {1'b0, src_y[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, src_c};

    if (gi == 0) begin : g_src
      assign src_x    = x;
      assign src_y    = y_eff;
      assign src_c    = cin_eff;
      assign src_v    = in_valid;
      assign sum_next = add[CHUNK-1:0];
    end else begin : g_src
      assign src_x    = stage[gi-1].g_fwd.xr_reg;
      assign src_y    = stage[gi-1].g_fwd.yr_reg;
      assign src_c    = stage[gi-1].carry_reg;
      assign src_v    = stage[gi-1].valid_reg;
      assign sum_next = {add[CHUNK-1:0], stage[gi-1].sum_reg};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (advance) begin
        valid_reg <= src_v;
        carry_reg <= add[CHUNK];
        sum_reg   <= sum_next;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      // Upper operand bits ride along until their stage adds them.
      logic [SW-CHUNK-1:0] xr_reg;
      logic [SW-CHUNK-1:0] yr_reg;

      always_ff @(posedge clk) begin
        if (advance) begin
          xr_reg <= src_x[SW-1:CHUNK];
          yr_reg <= src_y[SW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_reg;

      // Top chunk holds both operand sign bits and the result sign bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= (src_x[CHUNK-1] == src_y[CHUNK-1]) &&
                     (add[CHUNK-1] != src_x[CHUNK-1]);
        end
      end
    end
  end

  assign out_valid = stage[STAGES-1].valid_reg;
  assign s         = stage[STAGES-1].sum_reg;
  assign cout      = stage[STAGES-1].carry_reg;
  assign ovf       = stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed-vector bench for pipelined_carry_adder (WIDTH=16, CHUNK=4).
// Covers PIPELINED_CARRY_ADDER_SUB_EN builds as well as the default build.
module tb_pipelined_carry_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  pipelined_carry_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t        tbl [10];
  logic [17:0] expq[$];
  logic [17:0] e_cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          vcnt = 0;
  int          vfirst = -1;
  int          vlast = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output scoreboard: every transfer out must match the oldest accepted operand set.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      vcnt++;
      if (vfirst < 0) vfirst = cyc;
      vlast = cyc;
    end
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_result", {15'd0, out_valid}, 32'd0);
      end else begin
        e_cur = expq.pop_front();
        check("result", {14'd0, s, cout, ovf}, {14'd0, e_cur});
        $display("result s=%h cout=%b ovf=%b expected %h/%b/%b", s, cout, ovf,
                 e_cur[17:2], e_cur[1], e_cur[0]);
      end
    end
  end

  // Present one operand set from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input vec_t v, output int waits);
    x = v.x; y = v.y; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    if (in_ready) expq.push_back({v.es, v.ec, v.eo});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (expq.size() == 0) break;
    end
    check("drain", expq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   w;
    int   t0;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0003, 16'h0004, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    tbl[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[9] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
    tbl[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0};
    tbl[9] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_s", {16'd0, s}, 32'd0);
    check("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, valid after edge N+3
    send(tbl[0], w);
    t0 = cyc;
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", cyc - t0, 32'd3);
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 10; i++) begin
      send(tbl[i], w);
      check("table_in_ready", w, 32'd0);
    end
    in_valid = 1'b0;
    drain();

    // 256 back-to-back operand sets
    vcnt = 0; vfirst = -1; vlast = -1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        v = '{16'(i), 16'(j), 1'b0, 1'b0, 16'(i + j), 1'b0, 1'b0};
        send(v, w);
        check("stream_in_ready", w, 32'd0);
      end
    end
    in_valid = 1'b0;
    drain();
    check("stream_valid_cycles", vcnt, 32'd256);
    check("stream_contiguous", vlast - vfirst, 32'd255);

    // Backpressure: hold 0x1234 for 5 cycles, offered operand must wait
    out_ready = 1'b0;
    v = '{16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
    send(v, w);
    v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    send(v, w);
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    x = 16'h0100; y = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("stall_s_held", {16'd0, s}, 32'h1234);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      $display("stall cycle %0d s=%h in_ready=%b", t, s, in_ready);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    v = '{16'h0100, 16'h0011, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b0};
    send(v, w);
    in_valid = 1'b0;
    drain();

    // Reset with three operations in flight; operand offered during reset
    for (int i = 1; i < 4; i++) begin
      send(tbl[i], w);
    end
    rst = 1'b1;
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_s", {16'd0, s}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (8) @(negedge clk);

    // Pipeline still works after the flush
    @(posedge clk);
    #1;
    send(tbl[5], w);
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_carry_adder.md
PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4: bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set on x, y, cin, sub is valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 x, y  input  WIDTH  unsigned or two's-complement operands.
REQ-008 cin  input  1  carry into bit 0; ignored when sub is in effect.
REQ-009 sub  input  1  1 = compute x - y; behaviour governed by REQ-030/031.
REQ-010 out_valid  output  1  s, cout and ovf hold a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 s  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1; for subtraction, 1 = no borrow.
REQ-014 ovf  output  1  signed (two's-complement) overflow of the operation.

Function
REQ-015 advance = !out_valid | out_ready; in_ready SHALL equal advance combinationally.
REQ-016 Transfer in SHALL occur when in_valid & in_ready; transfer out SHALL occur when out_valid & out_ready.
REQ-017 The pipeline SHALL contain STAGES registered stages; stage k adds bits [k*CHUNK +: CHUNK] of both operands with the carry registered from stage k-1 (stage 0 uses cin, or 1 when subtracting).
REQ-018 Each stage SHALL carry a valid bit and the not-yet-added upper operand bits; all stages SHALL shift together only when advance = 1, otherwise hold unchanged.
REQ-019 With out_ready held 1, a result accepted at edge N SHALL appear with out_valid = 1 after edge N+STAGES-1 (latency STAGES cycles).
REQ-020 Throughput SHALL be one operation per cycle with no bubbles when in_valid and out_ready are held 1.
REQ-021 Bubbles (in_valid = 0 while advancing) SHALL propagate as invalid stages; out_valid SHALL be 0 for the matching cycles.
REQ-022 While out_valid = 1 and out_ready = 0, s, cout and ovf SHALL be held stable and no operand SHALL be accepted.
REQ-023 ovf SHALL be 1 exactly when both effective operands share a sign bit that differs from s[WIDTH-1].
REQ-024 Results SHALL emerge in acceptance order; no operand set SHALL be dropped or duplicated.

Reset
REQ-025 While rst = 1 at a clock edge, all stage valid bits, out_valid, s, cout and ovf SHALL become 0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL discard every in-flight operation; none SHALL reach the output afterwards.
REQ-028 An operand presented while rst = 1 SHALL NOT be accepted.
REQ-029 rst SHALL take priority over every other event at the same edge.

Configuration
REQ-030 With macro PIPELINED_CARRY_ADDER_SUB_EN defined, sub = 1 SHALL compute x + ~y + 1 (cin ignored) and ovf SHALL use ~y as the second operand.
REQ-031 Without PIPELINED_CARRY_ADDER_SUB_EN, the sub port SHALL remain present but be ignored (always add); no subtract logic SHALL be synthesised.

Verification (WIDTH=16, CHUNK=4, out_ready=1 unless stated)
REQ-032 x=0xFFFF, y=0x0001, cin=0 accepted at edge N -> after edge N+3: out_valid=1, s=0x0000, cout=1, ovf=0.
REQ-033 x=0x7FFF, y=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; x=0x0003, y=0x0004, cin=1 -> s=0x0008, cout=0, ovf=0.
REQ-034 256 back-to-back sets x=i, y=j (i,j in 0..15) -> 256 consecutive out_valid cycles, s=i+j in order, cout=0, in_ready never 0.
REQ-035 out_ready=0 for 5 cycles while result 0x1234 is valid -> s held at 0x1234, in_ready=0; next result follows on resume with none lost.
REQ-036 rst pulsed 1 cycle with 3 operations in flight -> out_valid=0 next cycle and no stale result ever appears.
REQ-037 With PIPELINED_CARRY_ADDER_SUB_EN: x=0x0005, y=0x0007, sub=1 -> s=0xFFFE, cout=0, ovf=0; x=0x8000, y=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
